// File: rtl/out_pattern_gen.sv
// Periodic / one-shot pulse generator: out high for H clocks, low for L clocks, then repeat or stop with done.
// Latency: out rises on the edge after start is sampled; no backpressure, stop aborts on the next edge.
module out_pattern_gen #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         mode,
    input  logic [W-1:0] high_n,
    input  logic [W-1:0] low_n,
    output logic         out,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   count, count_nxt;
    logic [W-1:0]   low_q, low_nxt;
    logic           mode_q, mode_nxt;
    logic           done_nxt;
    logic           launch;
    logic           launch_mode;
    logic           period_end;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            low_q  <= '0;
            mode_q <= 1'b0;
            out    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            low_q  <= low_nxt;
            mode_q <= mode_nxt;
            out    <= (state_nxt == HIGH);
            busy   <= (state_nxt != IDLE);
            done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        low_nxt     = low_q;
        mode_nxt    = mode_q;
        done_nxt    = 1'b0;
        launch      = 1'b0;
        launch_mode = mode_q;
        period_end  = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    launch      = 1'b1;
                    launch_mode = mode;
                end
            end
            HIGH: begin
                if (stop) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end else if (count == W'(1)) begin
                    if (low_q != '0) begin
                        state_nxt = LOW;
                        count_nxt = low_q;
                    end else begin
                        period_end = 1'b1;
                    end
                end else begin
                    count_nxt = count - W'(1);
                end
            end
            LOW: begin
                if (stop) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end else if (count == W'(1)) begin
                    period_end = 1'b1;
                end else begin
                    count_nxt = count - W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase

        // A continuous period end restarts exactly as a fresh start, so the next clock opens the new period.
        if (period_end) begin
            if (!mode_q) begin
                state_nxt = IDLE;
                count_nxt = '0;
                done_nxt  = 1'b1;
            end else begin
                launch      = 1'b1;
                launch_mode = 1'b1;
            end
        end

        if (launch) begin
            mode_nxt = launch_mode;
            low_nxt  = low_n;
            if (high_n != '0) begin
                state_nxt = HIGH;
                count_nxt = high_n;
            end else if (low_n != '0) begin
                state_nxt = LOW;
                count_nxt = low_n;
            end else begin
                // Empty pattern: one-shot still reports completion, continuous just falls idle.
                state_nxt = IDLE;
                count_nxt = '0;
                done_nxt  = !launch_mode;
            end
        end
    end

endmodule

// File: tb/tb_out_pattern_gen.sv
// Bench for out_pattern_gen: per-cycle vector table plus hand sequences, expected outputs queued and checked after each edge.
module tb_out_pattern_gen;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       mode  = 1'b0;
    logic [3:0] high_n = '0;
    logic [3:0] low_n  = '0;
    logic       out, busy, done;

    out_pattern_gen #(.W(4)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .mode   (mode),
        .high_n (high_n),
        .low_n  (low_n),
        .out    (out),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic       mode;
        logic [3:0] h;
        logic [3:0] l;
        logic       e_out;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    typedef struct {
        logic e_out;
        logic e_busy;
        logic e_done;
        int   idx;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   step_no = 0;

    function automatic vec_t v(input logic r, input logic s, input logic p, input logic m,
                               input int h, input int l, input logic eo, input logic eb, input logic ed);
        vec_t x;
        x.rst = r; x.start = s; x.stop = p; x.mode = m;
        x.h = 4'(h); x.l = 4'(l);
        x.e_out = eo; x.e_busy = eb; x.e_done = ed;
        return x;
    endfunction

    task automatic check(input string name, input int idx, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, req);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, then compare after the edge.
    task automatic apply(input vec_t x);
        exp_t e;
        @(negedge clock);
        reset  = x.rst;
        start  = x.start;
        stop   = x.stop;
        mode   = x.mode;
        high_n = x.h;
        low_n  = x.l;
        e.e_out = x.e_out; e.e_busy = x.e_busy; e.e_done = x.e_done; e.idx = step_no;
        sb.push_back(e);
        step_no++;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard step %0d: queue empty, expected 1 entry", step_no);
        end else begin
            e = sb.pop_front();
            check("out",  e.idx, out,  e.e_out);
            check("busy", e.idx, busy, e.e_busy);
            check("done", e.idx, done, e.e_done);
        end
    endtask

    initial begin
        // reset state, then continuous H=3 L=1 and a 2-clock reset mid-HIGH
        tbl.push_back(v(1,0,0,0, 0,0, 0,0,0));
        tbl.push_back(v(0,1,0,1, 3,1, 1,1,0));
        tbl.push_back(v(0,0,0,1, 3,1, 1,1,0));
        tbl.push_back(v(0,0,0,1, 3,1, 1,1,0));
        tbl.push_back(v(0,0,0,1, 3,1, 0,1,0));
        tbl.push_back(v(0,0,0,1, 3,1, 1,1,0));
        tbl.push_back(v(0,0,0,1, 3,1, 1,1,0));
        tbl.push_back(v(0,0,0,1, 3,1, 1,1,0));
        tbl.push_back(v(0,0,0,1, 3,1, 0,1,0));
        tbl.push_back(v(0,0,0,1, 3,1, 1,1,0));
        tbl.push_back(v(1,1,0,1, 3,1, 0,0,0));
        tbl.push_back(v(1,0,0,1, 3,1, 0,0,0));
        tbl.push_back(v(0,0,0,1, 3,1, 0,0,0));
        // one-shot H=2 L=3, with an ignored start while busy
        tbl.push_back(v(0,1,0,0, 2,3, 1,1,0));
        tbl.push_back(v(0,1,0,1, 5,5, 1,1,0));
        tbl.push_back(v(0,0,0,1, 5,5, 0,1,0));
        tbl.push_back(v(0,0,0,1, 5,5, 0,1,0));
        tbl.push_back(v(0,0,0,1, 5,5, 0,1,0));
        tbl.push_back(v(0,0,0,1, 5,5, 0,0,1));
        tbl.push_back(v(0,0,0,1, 5,5, 0,0,0));
        // continuous H=3 L=1, retuned to H=1 L=2 mid-HIGH
        tbl.push_back(v(0,1,0,1, 3,1, 1,1,0));
        tbl.push_back(v(0,0,0,1, 1,2, 1,1,0));
        tbl.push_back(v(0,0,0,1, 1,2, 1,1,0));
        tbl.push_back(v(0,0,0,1, 1,2, 0,1,0));
        tbl.push_back(v(0,0,0,1, 1,2, 1,1,0));
        tbl.push_back(v(0,0,0,1, 1,2, 0,1,0));
        tbl.push_back(v(0,0,0,1, 1,2, 0,1,0));
        tbl.push_back(v(0,0,0,1, 1,2, 1,1,0));
        tbl.push_back(v(0,0,1,1, 1,2, 0,0,0));
        // stop in LOW of H=4 L=4 with a simultaneous start, then stop+start in IDLE
        tbl.push_back(v(0,1,0,1, 4,4, 1,1,0));
        tbl.push_back(v(0,0,0,1, 4,4, 1,1,0));
        tbl.push_back(v(0,0,0,1, 4,4, 1,1,0));
        tbl.push_back(v(0,0,0,1, 4,4, 1,1,0));
        tbl.push_back(v(0,0,0,1, 4,4, 0,1,0));
        tbl.push_back(v(0,0,0,1, 4,4, 0,1,0));
        tbl.push_back(v(0,1,1,1, 4,4, 0,0,0));
        tbl.push_back(v(0,1,1,0, 4,4, 0,0,0));
        tbl.push_back(v(0,0,0,0, 4,4, 0,0,0));
        // empty patterns: one-shot H=0 L=0 gives done only; continuous H=0 L=0 ignored
        tbl.push_back(v(0,1,0,0, 0,0, 0,0,1));
        tbl.push_back(v(0,0,0,0, 0,0, 0,0,0));
        tbl.push_back(v(0,1,0,1, 0,0, 0,0,0));
        tbl.push_back(v(0,0,0,1, 0,0, 0,0,0));
        // one-shot H=0 L=2: low only
        tbl.push_back(v(0,1,0,0, 0,2, 0,1,0));
        tbl.push_back(v(0,0,0,0, 0,2, 0,1,0));
        tbl.push_back(v(0,0,0,0, 0,2, 0,0,1));
        // continuous H=1 L=0 resampling to 0/0 drops to IDLE without done
        tbl.push_back(v(0,1,0,1, 1,0, 1,1,0));
        tbl.push_back(v(0,0,0,1, 0,0, 0,0,0));
        tbl.push_back(v(0,0,0,1, 0,0, 0,0,0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // continuous H=15 L=0: out held high across several period boundaries
        apply(v(0,1,0,1, 15,0, 1,1,0));
        for (int i = 0; i < 40; i++) apply(v(0,0,0,1, 15,0, 1,1,0));
        apply(v(0,0,1,1, 15,0, 0,0,0));

        // continuous H=2 L=1 over many periods checks period length H+L with no gap
        apply(v(0,1,0,1, 2,1, 1,1,0));
        for (int p = 0; p < 5; p++) begin
            apply(v(0,0,0,1, 2,1, 1,1,0));
            apply(v(0,0,0,1, 2,1, 0,1,0));
            apply(v(0,0,0,1, 2,1, 1,1,0));
        end
        apply(v(1,0,0,1, 2,1, 0,0,0));
        apply(v(0,0,0,0, 2,1, 0,0,0));

        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
